pwm_decoder: RTL and testbench

- Receive-side counterpart of the team's PWM generator. Recovers the 2-bit frequency code and the 4-bit duty code (0..10) from an incoming PWM waveform.
- Sits at a chip input pin (loop-back or external PWM source). Feeds status/debug logic with decoded codes and an update strobe.
- Measures edge-to-edge period and high time in clock cycles, then maps them onto the generator's code tables. Also detects static (0 % / 100 %) and malformed waveforms.

---
 rtl/pwm_pkg.sv | 15 +
 rtl/pwm_sync_edge.sv | 34 +++
 rtl/pwm_decoder.sv | 141 ++++++++++++++
 tb/tb_pwm_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Code tables shared by the PWM generator and decoder: period per frequency
// code, the top duty code and the code types.
package pwm_pkg;

  typedef logic [1:0] freq_t;
  typedef logic [3:0] duty_t;

  localparam int PWM_PER_F0 = 80;
  localparam int PWM_PER_F1 = 40;
  localparam int PWM_PER_F2 = 20;
  localparam int PWM_PER_F3 = 10;

  localparam duty_t DUTY_MAX = 4'd10;

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, plus registered-level based
// rise/fall pulses (one clock wide, aligned with the synchronized level).
module pwm_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_prev;

  // NOTE: non-blocking assignments make the three flops shift in lockstep;
  // blocking ones would collapse the chain into a single stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_prev;
  assign o_fall  = ~r_s2 & r_prev;

endmodule

// File: rtl/pwm_decoder.sv
// Recovers frequency and duty codes from an incoming PWM waveform by timing
// edge-to-edge period and high time; flags static and malformed inputs.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 7,
  parameter int TIMEOUT = 127
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_pwm,
  output logic [1:0]  o_freq,
  output logic [3:0]  o_duty,
  output logic        o_valid,
  output logic        o_static,
  output logic        o_err,
  output logic        o_update
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;
  localparam logic [1:0] ST_STATIC  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);

  logic w_level;
  logic w_rise;
  logic w_fall;

  pwm_sync_edge u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_pwm),
    .o_level (w_level),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_comb assert (!(w_rise && w_fall));

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_high;
  freq_t            r_freq;
  duty_t            r_duty;
  logic             r_valid;
  logic             r_static;
  logic             r_err;
  logic             r_update;

  logic             w_per_ok;
  logic             w_legal;
  logic             w_timeout;
  freq_t            w_freq;
  duty_t            w_duty;
  logic [CNT_W-1:0] w_mask;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_per_ok = 1'b1;
    w_freq   = '0;
    w_mask   = '0;
    case (r_period)
      CNT_W'(PWM_PER_F0): begin w_freq = 2'd0; w_mask = CNT_W'(7); end
      CNT_W'(PWM_PER_F1): begin w_freq = 2'd1; w_mask = CNT_W'(3); end
      CNT_W'(PWM_PER_F2): begin w_freq = 2'd2; w_mask = CNT_W'(1); end
      CNT_W'(PWM_PER_F3): begin w_freq = 2'd3; w_mask = CNT_W'(0); end
      default:            w_per_ok = 1'b0;
    endcase
    // Step is a power of two, so "multiple of step" is a mask test and
    // the duty code is a plain shift.
    w_legal   = w_per_ok && (r_high != '0) && (r_high < r_period) &&
                ((r_high & w_mask) == '0);
    w_duty    = duty_t'(r_high >> (2'd3 - w_freq));
    w_timeout = (r_period == TIMEOUT_V) && (r_state != ST_STATIC);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_period <= '0;
      r_high   <= '0;
    end else if (w_rise) begin
      r_period <= CNT_W'(1);
      r_high   <= {{(CNT_W-1){1'b0}}, w_level};
    end else begin
      if (r_period != CNT_MAX) r_period <= r_period + 1'b1;
      if (w_level && (r_high != CNT_MAX)) r_high <= r_high + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_freq   <= '0;
      r_duty   <= '0;
      r_valid  <= 1'b0;
      r_static <= 1'b0;
      r_err    <= 1'b0;
      r_update <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (w_rise) begin
        if ((r_state == ST_MEASURE) || (r_state == ST_LOCKED)) begin
          r_state  <= ST_LOCKED;
          r_update <= 1'b1;
          r_static <= 1'b0;
          if (w_legal) begin
            r_freq  <= w_freq;
            r_duty  <= w_duty;
            r_valid <= 1'b1;
            r_err   <= 1'b0;
          end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b1;
          end
        end else begin
          // First edge after idle/static only opens a measurement window.
          r_state <= ST_MEASURE;
        end
      end else if (w_timeout) begin
        r_state  <= ST_STATIC;
        r_static <= 1'b1;
        r_valid  <= 1'b1;
        r_err    <= 1'b0;
        r_duty   <= w_level ? DUTY_MAX : duty_t'(0);
        r_update <= 1'b1;
      end
    end
  end

  assign o_freq   = r_freq;
  assign o_duty   = r_duty;
  assign o_valid  = r_valid;
  assign o_static = r_static;
  assign o_err    = r_err;
  assign o_update = r_update;

endmodule

// File: tb/tb_pwm_decoder.sv
// Bench for pwm_decoder: drives whole PWM periods and compares the decoded
// outputs with a table/division reference model of the code mapping.
module tb_pwm_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm = 1'b0;
  logic [1:0] o_freq;
  logic [3:0] o_duty;
  logic       o_valid;
  logic       o_static;
  logic       o_err;
  logic       o_update;

  always #5 clk = ~clk;

  pwm_decoder #(.CNT_W(7), .TIMEOUT(127)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_pwm    (pwm),
    .o_freq   (o_freq),
    .o_duty   (o_duty),
    .o_valid  (o_valid),
    .o_static (o_static),
    .o_err    (o_err),
    .o_update (o_update)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int upd_cnt = 0;

  always @(negedge clk) if (o_update === 1'b1) upd_cnt <= upd_cnt + 1;

  logic [8:0] act_vec;
  assign act_vec = {o_freq, o_duty, o_valid, o_static, o_err};

  logic [1:0] exp_freq;
  logic [3:0] exp_duty;
  logic       exp_valid, exp_static, exp_err;

  function automatic logic [8:0] exp_vec();
    return {exp_freq, exp_duty, exp_valid, exp_static, exp_err};
  endfunction

  function automatic void model_clear();
    exp_freq = '0; exp_duty = '0; exp_valid = 0; exp_static = 0; exp_err = 0;
  endfunction

  // Reference mapping: look up P in the period table, step = P/10, duty = H/step.
  function automatic void model_eval(input int p, input int h);
    int idx = -1;
    for (int i = 0; i < 4; i++) if (p == (80 >> i)) idx = i;
    exp_static = 0;
    if (idx >= 0 && h >= 1 && h <= p - 1 && (h % (p / 10)) == 0) begin
      exp_freq  = 2'(idx);
      exp_duty  = 4'(h / (p / 10));
      exp_valid = 1;
      exp_err   = 0;
    end else begin
      exp_valid = 0;
      exp_err   = 1;
    end
  endfunction

  task automatic cycle(input logic v);
    @(negedge clk);
    pwm = v;
  endtask

  task automatic drive_period(input int p, input int h);
    for (int i = 0; i < p; i++) cycle(i < h);
  endtask

  task automatic run_periods(input int p, input int h, input int n);
    for (int k = 0; k < n; k++) drive_period(p, h);
  endtask

  task automatic do_reset(input logic level);
    @(negedge clk);
    #2 rst_n = 1'b0;
    pwm = level;
    model_clear();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", act_vec, exp_vec());
    end
    n_tests++;
    if (o_update !== 1'b0) begin
      n_fail++; $display("FAIL reset_update: got %b expected 0", o_update);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int base = upd_cnt;
    drive_period(80, 40);
    #1;
    n_tests++;
    if (act_vec !== exp_vec() || upd_cnt - base != 0) begin
      n_fail++; $display("FAIL basic_first_period: got %h/%0d expected %h/0", act_vec, upd_cnt - base, exp_vec());
    end
    run_periods(80, 40, 2);
    model_eval(80, 40);
    #1;
    n_tests++;
    if (act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL basic_outputs: got %h expected %h", act_vec, exp_vec());
    end
    n_tests++;
    if (upd_cnt - base != 2) begin
      n_fail++; $display("FAIL basic_updates: got %0d expected 2", upd_cnt - base);
    end
  endtask

  task automatic test_sweep();
    for (int h = 1; h <= 9; h++) begin
      int base = upd_cnt;
      run_periods(10, h, 2);
      model_eval(10, h);
      #1;
      n_tests++;
      if (act_vec !== exp_vec() || upd_cnt - base != 2) begin
        n_fail++; $display("FAIL sweep_h%0d: got %h/%0d expected %h/2", h, act_vec, upd_cnt - base, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      int f = $urandom_range(3, 0);
      int p = 80 >> f;
      int h = $urandom_range(9, 1) * (p / 10);
      run_periods(p, h, 2);
      model_eval(p, h);
      #1;
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random_p%0d_h%0d: got %h expected %h", p, h, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_illegal();
    int bad_p [5] = '{30, 40, 50, 80, 79};
    int bad_h [5] = '{15, 5, 25, 3, 40};
    for (int k = 0; k < 5; k++) begin
      run_periods(bad_p[k], bad_h[k], 2);
      model_eval(bad_p[k], bad_h[k]);
      #1;
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL illegal_p%0d_h%0d: got %h expected %h", bad_p[k], bad_h[k], act_vec, exp_vec());
      end
      run_periods(20, 6, 2);
      model_eval(20, 6);
      #1;
      n_tests++;
      if (act_vec !== exp_vec()) begin
        n_fail++; $display("FAIL illegal_restore_%0d: got %h expected %h", k, act_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int base;
    run_periods(40, 28, 3);
    model_eval(40, 28);
    #1;
    n_tests++;
    if (act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL mid_locked: got %h expected %h", act_vec, exp_vec());
    end
    repeat (10) cycle(1'b1);
    #2 rst_n = 1'b0;
    pwm = 1'b0;
    model_clear();
    #1;
    n_tests++;
    if (act_vec !== exp_vec() || o_update !== 1'b0) begin
      n_fail++; $display("FAIL mid_async_reset: got %h expected %h", act_vec, exp_vec());
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = upd_cnt;
    drive_period(40, 28);
    #1;
    n_tests++;
    if (act_vec !== exp_vec() || upd_cnt - base != 0) begin
      n_fail++; $display("FAIL mid_first_rise: got %h/%0d expected %h/0", act_vec, upd_cnt - base, exp_vec());
    end
    drive_period(40, 28);
    model_eval(40, 28);
    #1;
    n_tests++;
    if (act_vec !== exp_vec() || upd_cnt - base != 1) begin
      n_fail++; $display("FAIL mid_second_rise: got %h/%0d expected %h/1", act_vec, upd_cnt - base, exp_vec());
    end
  endtask

  task automatic test_static(input logic level);
    int n = 0;
    int base;
    do_reset(level);
    base = upd_cnt;
    while (o_static !== 1'b1 && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    n_tests++;
    if (n < 120 || n > 140) begin
      n_fail++; $display("FAIL static%0b_delay: got %0d cycles expected 120..140", level, n);
    end
    exp_static = 1; exp_valid = 1; exp_err = 0; exp_freq = 0;
    exp_duty = level ? 4'd10 : 4'd0;
    n_tests++;
    if (act_vec !== exp_vec()) begin
      n_fail++; $display("FAIL static%0b_outputs: got %h expected %h", level, act_vec, exp_vec());
    end
    repeat (150) @(negedge clk);
    #1;
    n_tests++;
    if (act_vec !== exp_vec() || upd_cnt - base != 1) begin
      n_fail++; $display("FAIL static%0b_hold: got %h/%0d expected %h/1", level, act_vec, upd_cnt - base, exp_vec());
    end
  endtask

  task automatic test_static_resume();
    int base = upd_cnt;
    repeat (5) cycle(1'b0);
    drive_period(20, 8);
    #1;
    n_tests++;
    if (act_vec !== exp_vec() || upd_cnt - base != 0) begin
      n_fail++; $display("FAIL resume_held: got %h/%0d expected %h/0", act_vec, upd_cnt - base, exp_vec());
    end
    drive_period(20, 8);
    model_eval(20, 8);
    #1;
    n_tests++;
    if (act_vec !== exp_vec() || upd_cnt - base != 1) begin
      n_fail++; $display("FAIL resume_decoded: got %h/%0d expected %h/1", act_vec, upd_cnt - base, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_random();
    test_illegal();
    test_reset_mid();
    test_static(1'b1);
    test_static_resume();
    test_static(1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
